mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
Shares one 4x4 combinational multiplier (multiplier_4bit) between NUM_REQ independent requesters. Each requester offers an operand pair over a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the product is registered into a single response channel tagged with the requester ID. The block sits between the requesting engines and the multiplier datapath and provides fair, backpressure-aware access with 1-cycle latency.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CNT_W, 16, width of the saturating completed-operation counter
(ID_W = $clog2(NUM_REQ) is derived as a localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_a  input  NUM_REQ*4  packed operand A; requester i in bits [4i+3:4i]
req_b  input  NUM_REQ*4  packed operand B, same packing
req_ready  output  NUM_REQ  one-hot-or-zero accept strobe
rsp_valid  output  1  result valid
rsp_ready  input  1  downstream accepts result
rsp_p  output  8  product A*B
rsp_id  output  ID_W  index of the requester that produced rsp_p
op_count  output  CNT_W  number of accepted operations, saturating

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low forces all state immediately, independent of clk.
- Reset values: rsp_valid=0, rsp_p=0, rsp_id=0, op_count=0, round-robin pointer ptr=0. req_ready is combinational and therefore 0 while rsp_valid=0 and req_valid=0.
- Slot free: can_accept = !rsp_valid || rsp_ready. A single output register is used, with no skid buffer.
- Grant: the first i with req_valid[i]=1, searching from ptr upward and wrapping modulo NUM_REQ.
- req_ready[i] = can_accept && req_valid[i] && (i == grant). At most one bit is ever set. req_ready is combinational from req_valid, rsp_valid and rsp_ready.
- Accept (any req_ready bit high) at edge k:
  - rsp_p <= req_a[grant]*req_b[grant], taken from the multiplier instance fed by the grant mux.
  - rsp_id <= grant; rsp_valid <= 1.
  - ptr <= (grant+1) mod NUM_REQ.
  - op_count <= op_count+1, saturating at all-ones.
- No accept and rsp_ready=1: rsp_valid <= 0. rsp_p and rsp_id keep their last values.
- No accept and rsp_ready=0: all registers hold. While rsp_valid=1, rsp_p and rsp_id must stay stable.
- Latency: result valid 1 cycle after the accept edge. With rsp_ready held high, throughput is 1 op/cycle. A result consumed and a new accept in the same cycle is legal; rsp_valid stays 1.
- ptr advances only on accept, never on idle cycles. With a single active requester, that requester is granted back to back.
- Requester protocol: once req_valid[i] is raised, req_valid[i], req_a and req_b must hold until req_ready[i]. The arbiter never drops an offered request. Starvation bound: NUM_REQ-1 grants to others.
- Width rules: the product is exact in 8 bits (max 15*15=225). There is no overflow condition.
- Reset mid-operation: a pending result is discarded, ptr returns to 0, and op_count clears.
- Parameter check: NUM_REQ outside 2..8 raises an elaboration-time $error.

Decomposition:
- Package mul_arb_pkg:
  - OPW=4 and PW=8 constants.
  - mul_rsp_t struct {p[7:0], id}, using the package-maximum ID width 3.
- Sub-module mul_rr_picker (parameter N): inputs req[N-1:0] and ptr, outputs grant index and any_req. Purely combinational, using a double-width masked priority search.
- Existing multiplier_4bit instantiated once on the granted operands.
- Top level holds the output register, ptr and op_count.

Test Plan:
- Reset: rst_n low for 3 cycles with all req_valid=1 -> rsp_valid=0, op_count=0, no req_ready while rst_n low; first grant after release goes to requester 0.
- Single requester: req0 A=15 B=15 with rsp_ready=1 -> req_ready=0001 in cycle k; rsp_valid=1, rsp_p=225, rsp_id=0 in cycle k+1; op_count=1.
- Fairness: all 4 valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles. Operands A=i+1, B=3 give products 3,6,9,12,3,6.
- Backpressure: rsp_ready=0 after the first result (A=7 B=9) -> rsp_p holds 63 and req_ready=0 for 5 cycles. On rsp_ready=1, the next request is accepted in the same cycle and rsp_valid stays 1.
- Pointer wrap and skip: only req1 and req3 valid, ptr=2 -> grant 3, then 1, then 3. Zero operands A=0 B=13 -> rsp_p=0.
- Saturation: force op_count to 16'hFFFE, then perform 3 accepts -> op_count reaches 16'hFFFF and stays there. Asserting rst_n low mid-stall clears rsp_valid asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// ============================================================================
// mul_arb_pkg : shared constants and response record for mul_share_arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mul_arb_pkg;

  localparam int OPW      = 4;
  localparam int PW       = 8;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic [PW-1:0]       p;
    logic [ID_MAX_W-1:0] id;
  } mul_rsp_t;

endpackage

`default_nettype wire

// File: rtl/mul_rr_picker.sv
// ============================================================================
// mul_rr_picker : combinational round-robin pick, first request at or above
//                 ptr, wrapping. Revision 1.0
// ============================================================================
`default_nettype none

module mul_rr_picker #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] grant,
  output logic            any_req
);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [ID_W:0]  w_idx;
  logic           w_found;

  // Lower half holds only requests at/above ptr; upper half supplies the wrap.
  always_comb begin
    w_mask  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i >= int'(ptr));
    end
    w_dbl = {req, req & w_mask};
    for (int i = 0; i < 2*N; i++) begin
      if (!w_found && w_dbl[i]) begin
        w_found = 1'b1;
        w_idx   = (ID_W+1)'(i);
      end
    end
  end

  assign grant   = (w_idx >= (ID_W+1)'(N)) ? ID_W'(w_idx - (ID_W+1)'(N))
                                           : ID_W'(w_idx);
  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/multiplier_4bit.sv
// ============================================================================
// multiplier_4bit : unsigned 4x4 combinational multiplier, exact 8-bit product
// Revision        : 1.0
// ============================================================================
`default_nettype none

module multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

`default_nettype wire

// File: rtl/mul_share_arbiter.sv
// ============================================================================
// mul_share_arbiter : round-robin sharing of one 4x4 multiplier among NUM_REQ
//                     requesters, single registered tagged response channel
// Revision          : 1.0
// ============================================================================
`default_nettype none

module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*OPW-1:0] req_a,
  input  logic [NUM_REQ*OPW-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PW-1:0]          rsp_p,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       op_count
);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("mul_share_arbiter: NUM_REQ must be in 2..8");
    end
  endgenerate

  mul_rsp_t         r_rsp;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [ID_W-1:0]  w_grant;
  logic             w_any;
  logic             w_can_accept;
  logic             w_accept;
  logic [OPW-1:0]   w_a;
  logic [OPW-1:0]   w_b;
  logic [PW-1:0]    w_prod;
  logic [ID_W-1:0]  w_ptr_next;

  mul_rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req     (req_valid),
    .ptr     (r_ptr),
    .grant   (w_grant),
    .any_req (w_any)
  );

  // Gated by rst_n so nothing is handshaken while the block is held in reset.
  assign w_can_accept = rst_n && (!r_rsp_valid || rsp_ready);
  assign w_accept     = w_can_accept && w_any;

  always_comb begin
    req_ready = '0;
    if (w_accept) begin
      req_ready[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_a = req_a[i*OPW +: OPW];
        w_b = req_b[i*OPW +: OPW];
      end
    end
  end

  multiplier_4bit u_mul (
    .a (w_a),
    .b (w_b),
    .p (w_prod)
  );

  assign w_ptr_next = (w_grant == ID_W'(NUM_REQ-1)) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
      r_ptr       <= '0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_rsp.p     <= w_prod;
      r_rsp.id    <= ID_MAX_W'(w_grant);
      r_rsp_valid <= 1'b1;
      r_ptr       <= w_ptr_next;
      if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_p     = r_rsp.p;
  assign rsp_id    = r_rsp.id[ID_W-1:0];
  assign op_count  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
// ============================================================================
// tb_mul_share_arbiter : directed table-driven bench for mul_share_arbiter
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_mul_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_ready;

  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_p;
  logic [1:0]  rsp_id;
  logic [15:0] op_count;

  logic [3:0]  s_req_ready;
  logic        s_rsp_valid;
  logic [7:0]  s_rsp_p;
  logic [1:0]  s_rsp_id;
  logic [1:0]  s_op_count;

  int checks   = 0;
  int failures = 0;
  int model_cnt;
  int model_sat;

  mul_share_arbiter #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  // Narrow-counter twin exercises saturation with only a few accepts.
  mul_share_arbiter #(.NUM_REQ(4), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (s_req_ready),
    .rsp_valid (s_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (s_rsp_p),
    .rsp_id    (s_rsp_id),
    .op_count  (s_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_p;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] er, input logic ev, input logic [7:0] ep,
                               input logic [1:0] ei);
    vec_t r;
    r.valid = v; r.a = a; r.b = b;
    r.exp_ready = er; r.exp_valid = ev; r.exp_p = ep; r.exp_id = ei;
    return r;
  endfunction

  task automatic accepted();
    model_cnt++;
    if (model_sat < 3) model_sat++;
  endtask

  initial begin
    // fairness: all valid, A=i+1, B=3
    vecs[0]  = mkv(4'b1111, 16'h4321, 16'h3333, 4'b0001, 1'b1, 8'd3,   2'd0);
    vecs[1]  = mkv(4'b1111, 16'h4321, 16'h3333, 4'b0010, 1'b1, 8'd6,   2'd1);
    vecs[2]  = mkv(4'b1111, 16'h4321, 16'h3333, 4'b0100, 1'b1, 8'd9,   2'd2);
    vecs[3]  = mkv(4'b1111, 16'h4321, 16'h3333, 4'b1000, 1'b1, 8'd12,  2'd3);
    vecs[4]  = mkv(4'b1111, 16'h4321, 16'h3333, 4'b0001, 1'b1, 8'd3,   2'd0);
    vecs[5]  = mkv(4'b1111, 16'h4321, 16'h3333, 4'b0010, 1'b1, 8'd6,   2'd1);
    // wrap and skip from ptr=2: req1 0*13, req3 5*11
    vecs[6]  = mkv(4'b1010, 16'h5000, 16'hB0D0, 4'b1000, 1'b1, 8'd55,  2'd3);
    vecs[7]  = mkv(4'b1010, 16'h5000, 16'hB0D0, 4'b0010, 1'b1, 8'd0,   2'd1);
    vecs[8]  = mkv(4'b1010, 16'h5000, 16'hB0D0, 4'b1000, 1'b1, 8'd55,  2'd3);
    // idle drains the response; product and id hold
    vecs[9]  = mkv(4'b0000, 16'h5000, 16'hB0D0, 4'b0000, 1'b0, 8'd55,  2'd3);
    // lone requester granted back to back
    vecs[10] = mkv(4'b0001, 16'h000F, 16'h000F, 4'b0001, 1'b1, 8'd225, 2'd0);
    vecs[11] = mkv(4'b0001, 16'h000F, 16'h000F, 4'b0001, 1'b1, 8'd225, 2'd0);

    model_cnt = 0;
    model_sat = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = 16'h4321;
    req_b     = 16'h3333;
    rsp_ready = 1'b1;

    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_op_count",  32'(op_count),  32'h0);
    end
    chk("rst_rsp_p",  32'(rsp_p),  32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    rst_n = 1'b1;

    for (int r = 0; r < 12; r++) begin
      req_valid = vecs[r].valid;
      req_a     = vecs[r].a;
      req_b     = vecs[r].b;
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_req_ready", r), 32'(req_ready), 32'(vecs[r].exp_ready));
      step();
      if (vecs[r].exp_ready != 4'b0000) accepted();
      chk($sformatf("v%0d_rsp_valid", r), 32'(rsp_valid),  32'(vecs[r].exp_valid));
      chk($sformatf("v%0d_rsp_p", r),     32'(rsp_p),      32'(vecs[r].exp_p));
      chk($sformatf("v%0d_rsp_id", r),    32'(rsp_id),     32'(vecs[r].exp_id));
      chk($sformatf("v%0d_op_count", r),  32'(op_count),   32'(model_cnt));
      chk($sformatf("v%0d_sat_count", r), 32'(s_op_count), 32'(model_sat));
    end

    // backpressure: 7*9 held for 5 stalled cycles, then 2*5 accepted on release
    req_valid = 4'b0001; req_a = 16'h0007; req_b = 16'h0009; rsp_ready = 1'b1;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'h1);
    step();
    accepted();
    chk("bp_first_p",     32'(rsp_p),     32'd63);
    chk("bp_first_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b0; req_a = 16'h0002; req_b = 16'h0005;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_stall_ready", 32'(req_ready), 32'h0);
      chk("bp_stall_valid", 32'(rsp_valid), 32'h1);
      chk("bp_stall_p",     32'(rsp_p),     32'd63);
      chk("bp_stall_id",    32'(rsp_id),    32'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    step();
    accepted();
    chk("bp_release_valid", 32'(rsp_valid), 32'h1);
    chk("bp_release_p",     32'(rsp_p),     32'd10);
    chk("bp_op_count",      32'(op_count),  32'(model_cnt));
    chk("bp_sat_count",     32'(s_op_count), 32'd3);

    // stall a 6*7 result from requester 1, then reset asynchronously mid-cycle
    req_valid = 4'b0010; req_a = 16'h0060; req_b = 16'h0070; rsp_ready = 1'b1;
    #1;
    chk("st_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000; rsp_ready = 1'b0;
    step();
    chk("st_hold_valid", 32'(rsp_valid), 32'h1);
    chk("st_hold_p",     32'(rsp_p),     32'd42);
    chk("st_hold_id",    32'(rsp_id),    32'h1);
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'h3333; rsp_ready = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid),  32'h0);
    chk("arst_rsp_p",     32'(rsp_p),      32'h0);
    chk("arst_op_count",  32'(op_count),   32'h0);
    chk("arst_sat_count", 32'(s_op_count), 32'h0);
    chk("arst_req_ready", 32'(req_ready),  32'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    chk("post_rst_p",     32'(rsp_p),    32'd3);
    chk("post_rst_id",    32'(rsp_id),   32'h0);
    chk("post_rst_count", 32'(op_count), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
